// File: rtl/dma_burst_ctrl_if.sv
// Memory-bus bundle between the DMA engine (master) and the arbiter/memory side (slave).
interface dma_burst_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 13
);
   logic              bus_req;
   logic              bus_gnt;
   logic              ADE;
   logic [ADDR_W-1:0] address_Bus;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              Read;
   logic              Write;

   modport master (
      output bus_req,
      output ADE,
      output address_Bus,
      output wdata,
      output Read,
      output Write,
      input  bus_gnt,
      input  rdata
   );

   modport slave (
      input  bus_req,
      input  ADE,
      input  address_Bus,
      input  wdata,
      input  Read,
      input  Write,
      output bus_gnt,
      output rdata
   );
endinterface

// File: rtl/dma_burst_ctrl.sv
// Single-channel multi-word memory copy engine, programmed through four CPU registers.
// Define DMA_IRQ_EN to build the completion interrupt pulse; otherwise irq is tied low.
module dma_burst_ctrl #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 13,
   parameter int LEN_W     = 16,
   parameter int BASE_ADDR = 5000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cfg_wr,
   input  logic [31:0]       cfg_addr,
   input  logic [DATA_W-1:0] cfg_wdata,
   output logic [DATA_W-1:0] cfg_rdata,
   dma_burst_ctrl_if.master  bus,
   output logic              busy,
   output logic              irq
);

   localparam logic [31:0] BASE = 32'(BASE_ADDR);

   typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR, DONE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] src_reg, dst_reg, cur_src_reg, cur_dst_reg;
   logic [LEN_W-1:0]  len_reg, remaining_reg;
   logic [DATA_W-1:0] buffer_reg;
   logic              done_reg, aborted_reg;

   logic [3:0]        reg_hit;
   logic              gnt, start_req, abort_req, start_take, abort_take, word_done, last_word;
   logic              drv_req, drv_ade, drv_read, drv_write;
   logic [ADDR_W-1:0] drv_addr;
   logic [DATA_W-1:0] drv_wdata;
   logic              unused_wdata_bits;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hit
         assign reg_hit[gi] = (cfg_addr == BASE + 32'(gi));
      end
   endgenerate

   assign gnt        = bus.bus_gnt;
   assign busy       = (state_reg == REQ) || (state_reg == RD) ||
                       (state_reg == CAP) || (state_reg == WR);
   assign start_req  = cfg_wr && reg_hit[3] && cfg_wdata[0];
   assign abort_req  = cfg_wr && reg_hit[3] && cfg_wdata[1];
   // Abort beats a simultaneous start; it only has effect on a running transfer.
   assign abort_take = abort_req && busy;
   assign start_take = start_req && !abort_req && (state_reg == IDLE);
   assign word_done  = (state_reg == WR) && gnt;
   assign last_word  = (remaining_reg == LEN_W'(1));

   assign unused_wdata_bits = ^cfg_wdata;

   always_comb begin
      cfg_rdata = '0;
      if (reg_hit[0]) cfg_rdata = DATA_W'(src_reg);
      if (reg_hit[1]) cfg_rdata = DATA_W'(dst_reg);
      if (reg_hit[2]) cfg_rdata = DATA_W'(len_reg);
      if (reg_hit[3]) cfg_rdata = DATA_W'({aborted_reg, done_reg, busy});
   end

   // Bus drive is decoded from the state; a grant loss mid-burst parks the
   // engine in place with the request still raised.
   always_comb begin
      state_next = state_reg;
      drv_req    = 1'b0;
      drv_ade    = 1'b0;
      drv_read   = 1'b0;
      drv_write  = 1'b0;
      drv_addr   = '0;
      drv_wdata  = '0;
      case (state_reg)
         IDLE: begin
            if (start_take && (len_reg != '0)) state_next = REQ;
         end
         REQ: begin
            drv_req = 1'b1;
            if (gnt) state_next = RD;
         end
         RD: begin
            drv_req = 1'b1;
            if (gnt) begin
               drv_ade    = 1'b1;
               drv_read   = 1'b1;
               drv_addr   = cur_src_reg;
               state_next = CAP;
            end
         end
         CAP: begin
            drv_req = 1'b1;
            if (gnt) begin
               drv_ade    = 1'b1;
               state_next = WR;
            end
         end
         WR: begin
            drv_req = 1'b1;
            if (gnt) begin
               drv_ade    = 1'b1;
               drv_write  = 1'b1;
               drv_addr   = cur_dst_reg;
               drv_wdata  = buffer_reg;
               state_next = last_word ? DONE : RD;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (abort_take) state_next = IDLE;
   end

   assign bus.bus_req     = drv_req;
   assign bus.ADE         = drv_ade;
   assign bus.Read        = drv_read;
   assign bus.Write       = drv_write;
   assign bus.address_Bus = drv_addr;
   assign bus.wdata       = drv_wdata;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= IDLE;
         src_reg       <= '0;
         dst_reg       <= '0;
         len_reg       <= '0;
         cur_src_reg   <= '0;
         cur_dst_reg   <= '0;
         remaining_reg <= '0;
         buffer_reg    <= '0;
         done_reg      <= 1'b0;
         aborted_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (cfg_wr && !busy) begin
            if (reg_hit[0]) src_reg <= cfg_wdata[ADDR_W-1:0];
            if (reg_hit[1]) dst_reg <= cfg_wdata[ADDR_W-1:0];
            if (reg_hit[2]) len_reg <= cfg_wdata[LEN_W-1:0];
         end

         // Working copies keep SRC/DST/LEN intact so the same job can be re-started.
         if (start_take) begin
            aborted_reg <= 1'b0;
            if (len_reg != '0) begin
               cur_src_reg   <= src_reg;
               cur_dst_reg   <= dst_reg;
               remaining_reg <= len_reg;
               done_reg      <= 1'b0;
            end else begin
               done_reg <= 1'b1;
            end
         end

         if ((state_reg == CAP) && gnt) buffer_reg <= bus.rdata;

         if (word_done) begin
            cur_src_reg   <= cur_src_reg + 1'b1;
            cur_dst_reg   <= cur_dst_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            if (last_word) done_reg <= 1'b1;
         end

         if (abort_take) begin
            aborted_reg <= 1'b1;
            done_reg    <= 1'b0;
         end
      end
   end

`ifdef DMA_IRQ_EN
   logic irq_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         irq_reg <= 1'b0;
      end else begin
         irq_reg <= (state_reg == DONE) || (start_take && (len_reg == '0));
      end
   end

   assign irq = irq_reg;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Scoreboard bench for dma_burst_ctrl: expected bus reads/writes are queued at issue, a monitor pops them.
module tb_dma_burst_ctrl;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 13;
   localparam int LEN_W  = 16;
   localparam int BASE   = 5000;
`ifdef DMA_IRQ_EN
   localparam int IRQ_ON = 1;
`else
   localparam int IRQ_ON = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_wr;
   logic [31:0]       cfg_addr;
   logic [DATA_W-1:0] cfg_wdata;
   logic [DATA_W-1:0] cfg_rdata;
   logic              busy;
   logic              irq;
   logic              gnt;
   logic              rand_gnt;

   dma_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   dma_burst_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BASE_ADDR(BASE)
   ) dut (
      .CLK(clk), .RST(rst),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .bus(bus), .busy(busy), .irq(irq)
   );

   always #5 clk = ~clk;

   // Source words are a fixed function of address; sources never overlap destinations.
   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      logic [31:0] w;
      w = 32'(a);
      return (w * 32'h9E37_79B1) ^ {w[15:0], 16'h5A5A} ^ 32'h1234_0000;
   endfunction

   logic [DATA_W-1:0] wmem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rdata_reg = '0;

   always @(posedge clk) begin
      if (bus.Read)  rdata_reg <= pattern(bus.address_Bus);
      if (bus.Write) wmem[bus.address_Bus] <= bus.wdata;
   end

   assign bus.rdata   = rdata_reg;
   assign bus.bus_gnt = gnt;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int reads_seen = 0, writes_seen = 0, irq_count = 0, req_count = 0;
   int last_rd_cycle = 0, last_wr_cycle = 0;

   logic [ADDR_W-1:0] exp_rd_q[$];
   logic [ADDR_W-1:0] exp_wr_addr_q[$];
   logic [DATA_W-1:0] exp_wr_data_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on every strobe.
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (!rst) begin
            if (bus.bus_req) req_count++;
            if (irq) irq_count++;
            if (bus.bus_req && !gnt)
               check("quiet_without_grant", {bus.ADE, bus.Read, bus.Write}, 0);
            if (bus.Read) begin
               reads_seen++;
               last_rd_cycle = cycle;
               checks++;
               if (exp_rd_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_read: got addr 0x%0h, expected no read", bus.address_Bus);
               end else begin
                  checks--;
                  check("rd_addr", bus.address_Bus, exp_rd_q.pop_front());
               end
            end
            if (bus.Write) begin
               writes_seen++;
               last_wr_cycle = cycle;
               checks++;
               if (exp_wr_addr_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write: got addr 0x%0h, expected no write", bus.address_Bus);
               end else begin
                  checks--;
                  check("wr_addr", bus.address_Bus, exp_wr_addr_q.pop_front());
                  check("wr_data", bus.wdata, exp_wr_data_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int off, input logic [31:0] d);
      cfg_addr  = 32'(BASE + off);
      cfg_wdata = d;
      cfg_wr    = 1'b1;
      tick();
      cfg_wr    = 1'b0;
      cfg_addr  = '0;
   endtask

   task automatic cfg_read(input int off, output logic [31:0] d);
      cfg_addr = 32'(BASE + off);
      #1;
      d = cfg_rdata;
      cfg_addr = '0;
   endtask

   task automatic prog_regs(input int src, input int dst, input int len);
      cfg_write(0, 32'(src));
      cfg_write(1, 32'(dst));
      cfg_write(2, 32'(len));
   endtask

   // Reference: word i reads src+i and writes that word to dst+i, addresses wrapping at 2^ADDR_W.
   task automatic expect_xfer(input int src, input int dst, input int len);
      for (int i = 0; i < len; i++) begin
         exp_rd_q.push_back(ADDR_W'(src + i));
         exp_wr_addr_q.push_back(ADDR_W'(dst + i));
         exp_wr_data_q.push_back(pattern(ADDR_W'(src + i)));
      end
   endtask

   task automatic flush_expect();
      exp_rd_q.delete();
      exp_wr_addr_q.delete();
      exp_wr_data_q.delete();
   endtask

   task automatic wait_idle(input int limit, output int cyc);
      cyc = 0;
      while (busy && cyc < limit) begin
         if (rand_gnt) gnt = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
      end
      gnt = 1'b1;
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: got busy after %0d cycles, expected idle", cyc);
      end
   endtask

   task automatic run_xfer(input int src, input int dst, input int len, output int cyc);
      prog_regs(src, dst, len);
      expect_xfer(src, dst, len);
      cfg_write(3, 32'h1);
      wait_idle(3000, cyc);
      $display("xfer src=0x%0h dst=0x%0h len=%0d cycles=%0d", src, dst, len, cyc);
   endtask

   initial begin
      int          cyc, w0, r0, i0, k;
      logic [31:0] d;

      rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      gnt = 1'b0; rand_gnt = 1'b0;

      repeat (2) tick();
      check("rst_strobes", {bus.bus_req, bus.ADE, bus.Read, bus.Write, busy, irq}, 0);
      check("rst_addr", bus.address_Bus, 0);
      check("rst_wdata", bus.wdata, 0);
      rst = 1'b0;
      cfg_read(3, d); check("rst_ctrl", d, 0);
      cfg_read(0, d); check("rst_src", d, 0);
      cfg_read(2, d); check("rst_len", d, 0);
      $display("reset done");

      gnt = 1'b1;
      i0 = irq_count;
      run_xfer(32'h010, 32'h100, 1, cyc);
      check("single_latency", cyc, 4);
      check("single_rd_to_wr", last_wr_cycle - last_rd_cycle, 2);
      cfg_read(3, d); check("single_status", d, 3'b010);
      cfg_read(0, d); check("src_kept", d, 32'h010);
      cfg_read(4, d); check("outside_map_hi", d, 0);
      cfg_read(-1, d); check("outside_map_lo", d, 0);
      repeat (2) tick();
      check("single_irq", irq_count - i0, IRQ_ON);

      expect_xfer(32'h010, 32'h100, 1);
      cfg_write(3, 32'h1);
      wait_idle(100, cyc);
      $display("restart src=0x010 dst=0x100 len=1 cycles=%0d", cyc);
      check("restart_latency", cyc, 4);

      i0 = irq_count;
      run_xfer(32'h020, 32'h1FFE, 4, cyc);
      check("burst_latency", cyc, 13);
      repeat (3) tick();
      check("burst_irq", irq_count - i0, IRQ_ON);
      check("wrap_mem0", wmem[0], pattern(13'h022));
      check("wrap_mem1", wmem[1], pattern(13'h023));

      // Grant loss during word 2 of a 3-word burst.
      prog_regs(32'h040, 32'h1100, 3);
      expect_xfer(32'h040, 32'h1100, 3);
      r0 = reads_seen; w0 = writes_seen;
      cfg_write(3, 32'h1);
      k = 0;
      while (reads_seen < r0 + 2 && k < 100) begin tick(); k++; end
      check("gnt_loss_reached_word2", reads_seen - r0, 2);
      gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("gnt_loss_req_held", {bus.bus_req, busy}, 2'b11);
      end
      gnt = 1'b1;
      wait_idle(100, cyc);
      $display("gnt-loss xfer len=3 words=%0d", writes_seen - w0);
      check("gnt_loss_words", writes_seen - w0, 3);

      // Zero-length start completes without touching the bus.
      prog_regs(32'h070, 32'h1300, 0);
      r0 = req_count; i0 = irq_count;
      cfg_write(3, 32'h1);
      check("len0_busy", busy, 0);
      cfg_read(3, d); check("len0_status", d, 3'b010);
      repeat (3) tick();
      check("len0_no_req", req_count - r0, 0);
      check("len0_irq", irq_count - i0, IRQ_ON);
      $display("len0 start done");

      // Start and abort together while idle: nothing starts.
      prog_regs(32'h070, 32'h1300, 2);
      r0 = req_count;
      cfg_write(3, 32'h3);
      check("start_abort_busy", busy, 0);
      repeat (3) tick();
      check("start_abort_no_req", req_count - r0, 0);
      $display("start+abort idle ignored");

      // Register writes while busy are dropped.
      prog_regs(32'h080, 32'h1400, 4);
      expect_xfer(32'h080, 32'h1400, 4);
      cfg_write(3, 32'h1);
      tick();
      cfg_write(0, 32'h0ABC);
      cfg_write(2, 32'h0009);
      cfg_read(0, d); check("src_busy_locked", d, 32'h080);
      cfg_read(2, d); check("len_busy_locked", d, 32'h004);
      wait_idle(100, cyc);
      $display("busy-locked xfer len=4 cycles=%0d", cyc);

      // Abort during word 3 of an 8-word burst.
      prog_regs(32'h060, 32'h1200, 8);
      expect_xfer(32'h060, 32'h1200, 8);
      w0 = writes_seen; i0 = irq_count;
      cfg_write(3, 32'h1);
      k = 0;
      while (writes_seen < w0 + 2 && k < 100) begin tick(); k++; end
      check("abort_reached_word3", writes_seen - w0, 2);
      cfg_write(3, 32'h2);
      check("abort_req_dropped", {bus.bus_req, busy}, 2'b00);
      cfg_read(3, d); check("abort_status", d, 3'b100);
      flush_expect();
      repeat (4) tick();
      check("abort_at_most_3_words", (writes_seen - w0) <= 3, 1'b1);
      check("abort_no_irq", irq_count - i0, 0);
      $display("abort xfer len=8 words=%0d", writes_seen - w0);

      // Randomised transfers with a flickering grant.
      for (int n = 0; n < 20; n++) begin
         int s, t, l;
         s = 32'h200 + $urandom_range(0, 32'h5FF);
         t = 32'h1000 + $urandom_range(0, 32'h7FF);
         l = $urandom_range(1, 16);
         rand_gnt = 1'b1;
         run_xfer(s, t, l, cyc);
         rand_gnt = 1'b0;
         cfg_read(3, d); check("rand_status", d, 3'b010);
      end

      // Reset in the middle of a burst.
      prog_regs(32'h090, 32'h1500, 8);
      expect_xfer(32'h090, 32'h1500, 8);
      cfg_write(3, 32'h1);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      check("midrst_strobes", {bus.bus_req, bus.ADE, bus.Read, bus.Write, busy}, 0);
      cfg_read(0, d); check("midrst_src", d, 0);
      flush_expect();
      rst = 1'b0;
      repeat (3) tick();
      $display("mid-burst reset done");

      check("scoreboard_drained", exp_wr_addr_q.size() + exp_rd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
